// File: rtl/fetch_pc_if.sv
// fetch_pc_if: branch-control, instruction-memory and decode-side signals of
// the fetch stage. The fetch unit connects through the master modport; the
// surrounding environment (branch unit, memory, decode) uses the slave modport.
interface fetch_pc_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [1:0]        muxc5;
  logic              ex_valid;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    input  muxc5, ex_valid, br_target, jmp_target,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output muxc5, ex_valid, br_target, jmp_target,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage. Owns the PC, issues word-addressed
// requests, matches in-order responses against a 2-entry tag queue and
// buffers {pc, instr} in a 2-entry output FIFO toward decode. A taken branch
// or jump redirects the PC, flushes both queues and drops the responses still
// in flight.
// Optional feature: define FETCH_STATS_EN to add a saturating 16-bit
// redirect_cnt output.
module fetch_pc_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_pc_if.master   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]  redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  // in-flight bookkeeping
  logic [1:0]        outstanding;
  logic [1:0]        drop_cnt;

  // tag queue of issued addresses (tag0 is the oldest)
  logic [ADDR_W-1:0] tag0;
  logic [ADDR_W-1:0] tag1;
  logic [1:0]        tq_cnt;

  // output FIFO: head entry is the registered decode-side output
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;
  logic [ADDR_W-1:0] tail_pc;
  logic [DATA_W-1:0] tail_instr;
  logic [1:0]        fifo_cnt;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              rsp;
  logic              keep;
  logic              drop;
  logic              pop;
  logic [2:0]        occ;
  logic              req;
  logic              accept;
  logic [1:0]        inflight_left;

  // Request credit and response classification
  always_comb begin
    redirect      = bus.ex_valid && ((bus.muxc5 == 2'b10) || (bus.muxc5 == 2'b01));
    target        = (bus.muxc5 == 2'b10) ? bus.br_target : bus.jmp_target;
    // a strobe with nothing outstanding is a protocol error and is ignored
    rsp           = bus.imem_rvalid && (outstanding != 2'd0);
    keep          = rsp && (drop_cnt == 2'd0) && !redirect;
    drop          = rsp && (drop_cnt != 2'd0) && !redirect;
    pop           = (fifo_cnt != 2'd0) && bus.if_ready && !redirect;
    inflight_left = outstanding - {1'b0, rsp};
    // A same-cycle pop frees a FIFO slot before any new response can land,
    // so it counts as credit; this keeps one instruction per cycle flowing
    // with single-cycle memory while still bounding occupancy to two.
    occ           = {1'b0, outstanding} + {1'b0, fifo_cnt} - {2'b00, pop};
    req           = (state == FETCH) && !redirect && (occ < 3'd2);
    accept        = req && bus.imem_gnt;
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (fifo_cnt != 2'd0);
  assign bus.if_pc     = head_pc;
  assign bus.if_instr  = head_instr;

  // Control FSM: start fetching after reset, wait out stale responses after a redirect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (redirect && (inflight_left != 2'd0)) state <= DRAIN;
        DRAIN: begin
          if (redirect) begin
            state <= DRAIN;
          end else if ((drop_cnt == 2'd0) || ((drop_cnt == 2'd1) && drop)) begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter: redirect wins over sequential advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (accept) begin
      pc <= pc + 1'b1;
    end
  end

  // Outstanding-request and drop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, accept} - {1'b0, rsp};
      if (redirect) begin
        // everything still in flight after this cycle belongs to the old path
        drop_cnt <= inflight_left;
      end else if (drop) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  // Tag queue: push issued PC on accept, pop oldest on a kept response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tq_cnt <= 2'd0;
    end else if (redirect) begin
      tq_cnt <= 2'd0;
    end else begin
      tq_cnt <= tq_cnt + {1'b0, accept} - {1'b0, keep};
      case ({accept, keep})
        2'b10: begin
          if (tq_cnt == 2'd0) tag0 <= pc;
          else                tag1 <= pc;
        end
        2'b01: tag0 <= tag1;
        2'b11: begin
          if (tq_cnt == 2'd1) begin
            tag0 <= pc;
          end else begin
            tag0 <= tag1;
            tag1 <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Output FIFO: kept responses enter with their tag, decode pops the head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_cnt   <= 2'd0;
      head_pc    <= '0;
      head_instr <= '0;
    end else if (redirect) begin
      fifo_cnt <= 2'd0;
    end else begin
      fifo_cnt <= fifo_cnt + {1'b0, keep} - {1'b0, pop};
      case ({keep, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            head_pc    <= tag0;
            head_instr <= bus.imem_rdata;
          end else begin
            tail_pc    <= tag0;
            tail_instr <= bus.imem_rdata;
          end
        end
        2'b01: begin
          if (fifo_cnt == 2'd2) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
          end
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head_pc    <= tag0;
            head_instr <= bus.imem_rdata;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= tag0;
            tail_instr <= bus.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating count of taken redirects
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt <= 16'd0;
    end else if (redirect && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule
